// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and div_unit.
//   master (execute stage): drives START, KILL, X, Y, Is32Bit, ALUOp;
//                           observes BUSY, DONE, OUTPUT.
//   slave  (div_unit)     : the reverse.
// Signal names match the original flat port list of div_unit.
interface div_unit_if;
    logic        START;
    logic        KILL;
    logic [63:0] X;
    logic [63:0] Y;
    logic        Is32Bit;
    logic [14:0] ALUOp;
    logic        BUSY;
    logic        DONE;
    logic [63:0] OUTPUT;

    modport master (
        output START, KILL, X, Y, Is32Bit, ALUOp,
        input  BUSY, DONE, OUTPUT
    );

    modport slave (
        input  START, KILL, X, Y, Is32Bit, ALUOp,
        output BUSY, DONE, OUTPUT
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative signed divide/remainder for the RV64I execute stage.
//   CLK           clock, rising edge
//   RST           synchronous active-high reset
//   bus.START     request, sampled only in IDLE
//   bus.KILL      flush, aborts any operation in progress (wins over START)
//   bus.X / Y     64-bit two's complement dividend / divisor
//   bus.Is32Bit   word op: uses X[31:0] / Y[31:0], result sign-extended
//   bus.ALUOp     one-hot op: 15'h0400 div, 15'h0800 rem
//   bus.BUSY      high in every non-IDLE state
//   bus.DONE      one-cycle pulse, OUTPUT valid from this cycle
//   bus.OUTPUT    registered result, held until the next accepted START
// Optional feature: define DIV_FASTZERO_EN to finish |X| < |Y| operations
// through the special-case path instead of the full iteration.
module div_unit (
    input  logic       CLK,
    input  logic       RST,
    div_unit_if.slave  bus
);
    localparam logic [14:0] OP_DIV = 15'h0400;
    localparam logic [14:0] OP_REM = 15'h0800;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE_S} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] out_q, out_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] dvsr_q, dvsr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        is_rem_q, is_rem_d;
    logic        word_q, word_d;
    logic        x_neg_q, x_neg_d;
    logic        q_neg_q, q_neg_d;

    logic        op_ok, accept, x_neg, y_neg, special;
    logic [63:0] x_ext, y_ext, x_mag, y_mag, special_res;
    logic [64:0] shifted, trial;
    logic [63:0] q_signed, r_signed, fix_res;

    always_comb begin
        // Operand decode: word ops sign-extend the low word first so one
        // negate/compare path serves both widths.
        op_ok  = (bus.ALUOp == OP_DIV) || (bus.ALUOp == OP_REM);
        accept = bus.START && !bus.KILL && op_ok && (state_q == IDLE);
        x_ext  = bus.Is32Bit ? {{32{bus.X[31]}}, bus.X[31:0]} : bus.X;
        y_ext  = bus.Is32Bit ? {{32{bus.Y[31]}}, bus.Y[31:0]} : bus.Y;
        x_neg  = x_ext[63];
        y_neg  = y_ext[63];
        x_mag  = x_neg ? (~x_ext + 64'd1) : x_ext;
        y_mag  = y_neg ? (~y_ext + 64'd1) : y_ext;

        special     = 1'b0;
        special_res = '0;
        if (y_ext == '0) begin
            special     = 1'b1;
            special_res = (bus.ALUOp == OP_REM) ? x_ext : '1;
        end else if (y_ext == '1 &&
                     x_ext == (bus.Is32Bit ? 64'hFFFF_FFFF_8000_0000
                                           : 64'h8000_0000_0000_0000)) begin
            special     = 1'b1;
            special_res = (bus.ALUOp == OP_REM) ? '0 : x_ext;
        end
`ifdef DIV_FASTZERO_EN
        else if (x_mag < y_mag) begin
            special     = 1'b1;
            special_res = (bus.ALUOp == OP_REM) ? x_ext : '0;
        end
`endif

        // Restoring step: bring the next dividend bit into the partial
        // remainder; bit 64 of the trial difference is set when it underflows.
        shifted = {rem_q, quo_q[63]};
        trial   = shifted - {1'b0, dvsr_q};

        q_signed = q_neg_q ? (~quo_q + 64'd1) : quo_q;
        r_signed = x_neg_q ? (~rem_q + 64'd1) : rem_q;
        fix_res  = is_rem_q ? r_signed : q_signed;
        if (word_q)
            fix_res = {{32{fix_res[31]}}, fix_res[31:0]};

        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        out_d    = out_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        word_d   = word_q;
        x_neg_d  = x_neg_q;
        q_neg_d  = q_neg_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d = (bus.ALUOp == OP_REM);
                    word_d   = bus.Is32Bit;
                    x_neg_d  = x_neg;
                    q_neg_d  = x_neg ^ y_neg;
                    rem_d    = '0;
                    // Word magnitudes sit in the top half so the shift always
                    // consumes from bit 63; 32 steps leave the quotient low.
                    quo_d    = bus.Is32Bit ? {x_mag[31:0], 32'd0} : x_mag;
                    dvsr_d   = y_mag;
                    cnt_d    = bus.Is32Bit ? 7'd32 : 7'd64;
                    busy_d   = 1'b1;
                    if (special) begin
                        out_d   = special_res;
                        state_d = DONE_S;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[64]) begin
                    rem_d = trial[63:0];
                    quo_d = {quo_q[62:0], 1'b1};
                end else begin
                    rem_d = shifted[63:0];
                    quo_d = {quo_q[62:0], 1'b0};
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1)
                    state_d = FIX;
            end
            FIX: begin
                out_d   = fix_res;
                state_d = DONE_S;
            end
            DONE_S: begin
                // Two cycles here: one to raise DONE, one to drop it, so BUSY
                // stays high through the DONE cycle.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.KILL && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            out_d   = out_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            x_neg_q  <= 1'b0;
            q_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            word_q   <= word_d;
            x_neg_q  <= x_neg_d;
            q_neg_q  <= q_neg_d;
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.OUTPUT = out_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    localparam logic [14:0] OP_DIV = 15'h0400;
    localparam logic [14:0] OP_REM = 15'h0800;
`ifdef DIV_FASTZERO_EN
    localparam int FZ_EDGE = 1;
`else
    localparam int FZ_EDGE = 66;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    div_unit_if dif();

    div_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        dif.START   = 1'b0;
        dif.KILL    = 1'b0;
        dif.X       = '0;
        dif.Y       = '0;
        dif.Is32Bit = 1'b0;
        dif.ALUOp   = '0;
    endtask

    // Issue one op at edge 0 and watch edges 1..exp_edge+1.
    task automatic run_op(input string name, input logic [63:0] x, input logic [63:0] y,
                          input logic w, input logic [14:0] op,
                          input logic [63:0] exp_out, input int exp_edge);
        int          done_at;
        bit          busy_ok;
        logic [63:0] out_at_done;
        done_at     = -1;
        busy_ok     = 1'b1;
        out_at_done = 'x;
        @(negedge clk);
        dif.START = 1'b1; dif.X = x; dif.Y = y; dif.Is32Bit = w; dif.ALUOp = op;
        @(posedge clk); #1;
        dif.START = 1'b0;
        if (dif.BUSY !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= exp_edge + 1; k++) begin
            @(posedge clk); #1;
            if (dif.BUSY !== (k <= exp_edge)) busy_ok = 1'b0;
            if (dif.DONE === 1'b1 && done_at < 0) done_at = k;
            if (k == exp_edge) out_at_done = dif.OUTPUT;
        end
        vectors++;
        if (done_at != exp_edge) begin
            miscompares++;
            $display("FAIL %s done_edge: got %0d expected %0d", name, done_at, exp_edge);
        end
        vectors++;
        if (out_at_done !== exp_out) begin
            miscompares++;
            $display("FAIL %s output: got %h expected %h", name, out_at_done, exp_out);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL %s busy_window: got bad BUSY pattern expected high for edges 0..%0d", name, exp_edge);
        end
        for (int k = 0; k < 100 && dif.BUSY !== 1'b0; k++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (dif.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s drain: got BUSY=%b expected 0", name, dif.BUSY);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (dif.BUSY !== 1'b0 || dif.DONE !== 1'b0 || dif.OUTPUT !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h expected 0 0 0",
                     dif.BUSY, dif.DONE, dif.OUTPUT);
        end
    endtask

    task automatic test_div64();
        run_op("div_100_7", 64'd100, 64'd7, 1'b0, OP_DIV, 64'd14, 66);
        run_op("rem_100_7", 64'd100, 64'd7, 1'b0, OP_REM, 64'd2, 66);
        run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, OP_DIV, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, OP_REM, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    endtask

    task automatic test_special();
        run_op("div_by0", 64'd5, 64'd0, 1'b0, OP_DIV, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_by0", 64'd5, 64'd0, 1'b0, OP_REM, 64'd5, 1);
        run_op("div_ovf", 64'h8000_0000_0000_0000, '1, 1'b0, OP_DIV, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", 64'h8000_0000_0000_0000, '1, 1'b0, OP_REM, 64'd0, 1);
    endtask

    task automatic test_word();
        run_op("divw", 64'h0000_0001_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, OP_DIV,
               64'hFFFF_FFFF_FFFF_FFF2, 34);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, OP_DIV,
               64'hFFFF_FFFF_8000_0000, 1);
    endtask

    task automatic test_fastzero();
        run_op("div_3_10", 64'd3, 64'd10, 1'b0, OP_DIV, 64'd0, FZ_EDGE);
        run_op("rem_3_10", 64'd3, 64'd10, 1'b0, OP_REM, 64'd3, FZ_EDGE);
    endtask

    task automatic test_illegal_op();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        dif.START = 1'b1; dif.X = 64'd100; dif.Y = 64'd7; dif.ALUOp = 15'h0001;
        @(posedge clk); #1;
        dif.START = 1'b0;
        vectors++;
        if (dif.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_op_busy: got %b expected 0", dif.BUSY);
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (dif.DONE !== 1'b0 || dif.BUSY !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL illegal_op_activity: got BUSY/DONE activity expected none");
        end
    endtask

    // A divide-by-zero START during a long op must not be taken.
    task automatic test_start_while_busy();
        logic [63:0] out_at_done;
        int          done_at;
        done_at = -1;
        out_at_done = 'x;
        @(negedge clk);
        dif.START = 1'b1; dif.X = 64'd100; dif.Y = 64'd7; dif.Is32Bit = 1'b0; dif.ALUOp = OP_DIV;
        @(posedge clk); #1;
        dif.START = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin
                dif.START = 1'b1; dif.X = 64'd5; dif.Y = 64'd0;
            end
            @(posedge clk); #1;
            if (k == 5) dif.START = 1'b0;
            if (dif.DONE === 1'b1 && done_at < 0) begin
                done_at = k;
                out_at_done = dif.OUTPUT;
            end
        end
        vectors++;
        if (done_at != 66 || out_at_done !== 64'd14) begin
            miscompares++;
            $display("FAIL start_while_busy: got edge %0d out %h expected edge 66 out %h",
                     done_at, out_at_done, 64'd14);
        end
    endtask

    task automatic start_and_wait10();
        @(negedge clk);
        dif.START = 1'b1; dif.X = 64'd100; dif.Y = 64'd7; dif.Is32Bit = 1'b0; dif.ALUOp = OP_DIV;
        @(posedge clk); #1;
        dif.START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_kill(input logic [63:0] prev_out);
        bit done_seen;
        done_seen = 1'b0;
        start_and_wait10();
        vectors++;
        if (dif.BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_pre_busy: got %b expected 1", dif.BUSY);
        end
        dif.KILL = 1'b1;
        @(posedge clk); #1;
        dif.KILL = 1'b0;
        vectors++;
        if (dif.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_busy: got %b expected 0", dif.BUSY);
        end
        repeat (70) begin
            @(posedge clk); #1;
            if (dif.DONE !== 1'b0) done_seen = 1'b1;
        end
        vectors++;
        if (done_seen || dif.OUTPUT !== prev_out) begin
            miscompares++;
            $display("FAIL kill_after: got done_seen=%b out=%h expected 0 %h", done_seen, dif.OUTPUT, prev_out);
        end
    endtask

    task automatic test_reset_abort();
        start_and_wait10();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (dif.BUSY !== 1'b0 || dif.DONE !== 1'b0 || dif.OUTPUT !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_abort: got busy=%b done=%b out=%h expected 0 0 0",
                     dif.BUSY, dif.DONE, dif.OUTPUT);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        test_reset();
        test_div64();
        test_special();
        test_word();
        test_fastzero();
        test_illegal_op();
        test_start_while_busy();
        test_kill(64'd14);
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative signed divide/remainder unit for the RV64I execute stage. It sits beside the ALU, takes the same X/Y operands, Is32Bit flag and one-hot ALUOp encoding, and implements the div (15'h0400) and rem (15'h0800) operations that the single-cycle ALU does not provide. Its OUTPUT feeds the same execute-result mux as the ALU result. The pipeline stalls on BUSY until DONE pulses.

## Interface
Parameters:
- none; widths are fixed to RV64.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  request; sampled only in IDLE.
- KILL  in  1  pipeline flush; aborts any operation in progress.
- X  in  64  dividend, two's complement.
- Y  in  64  divisor, two's complement.
- Is32Bit  in  1  word operation (divw/remw): uses X[31:0] and Y[31:0] only.
- ALUOp  in  15  one-hot op: 15'h0400 selects div, 15'h0800 selects rem.
- BUSY  out  1  high in every non-IDLE state.
- DONE  out  1  one-cycle pulse; OUTPUT is valid from this cycle.
- OUTPUT  out  64  registered result; holds its value until the next accepted START.

## Operation
- Reset values: state IDLE, BUSY=0, DONE=0, OUTPUT=0. The internal remainder, quotient and counter registers are also cleared.
- An operation is accepted when START=1, the state is IDLE, and ALUOp is 15'h0400 or 15'h0800. Any other ALUOp is ignored: the unit stays in IDLE and does not assert BUSY.
- On accept, the unit latches the operation, Is32Bit, the operand signs and the operand magnitudes. In word mode, the signs are X[31]/Y[31] and the magnitudes come from the low 32 bits.
- States:
  - IDLE → CALC on accept. IDLE → DONE_S on accept when the operation is a special case.
  - CALC runs one restoring shift-subtract step per cycle for N cycles (N=64, or N=32 if Is32Bit). It then goes to FIX.
  - FIX applies the result signs and loads OUTPUT, then goes to DONE_S.
  - DONE_S asserts DONE for one cycle, then returns to IDLE.
- Sign rules:
  - The quotient is negative when the operand signs differ; it is truncated toward zero.
  - The remainder takes the sign of the dividend.
- Special cases, detected at accept:
  - Divide by zero (divisor = 0): div returns all ones; rem returns the dividend.
  - Overflow (dividend = most-negative value, divisor = −1): div returns the dividend; rem returns 0.
- Word mode: the 32-bit result is sign-extended to 64 bits before it is loaded into OUTPUT.
- KILL:
  - KILL=1 in any non-IDLE state returns the unit to IDLE on the next edge.
  - No DONE is generated, and OUTPUT is not updated.
  - KILL takes priority over START in the same cycle.
- RST asserted mid-operation returns every register to its reset value on the next edge.

## Timing
- START is sampled at edge 0.
- Normal operation: DONE is high between edge N+2 and edge N+3, i.e. 66 edges for a 64-bit op and 34 edges for a word op.
- Special cases: DONE is high between edge 1 and edge 2.
- BUSY is high from edge 0 until the edge on which DONE falls.
- A new START can be accepted in the cycle after DONE, since the unit is back in IDLE. Back-to-back issue therefore has zero dead cycles beyond the DONE cycle.
- START while BUSY=1 is ignored; the requester must hold the op until it is accepted.

## Configuration
- DIV_FASTZERO_EN, when defined: at accept, if |dividend| < |divisor| (which includes dividend = 0), the operation is treated as a special case. div returns 0; rem returns the sign-extended dividend. DONE follows the special-case timing (edge 1).
- When undefined: these operations run the full N-cycle iteration and produce the same values with normal timing.

## Test plan
- 64-bit div, X=100, Y=7 → OUTPUT=14, DONE at edge 66, BUSY high for edges 0–66. Repeat as rem → OUTPUT=2.
- Signed cases, X=0xFFFF_FFFF_FFFF_FFF9 (−7), Y=2: div → 0xFFFF_FFFF_FFFF_FFFD (−3); rem → 0xFFFF_FFFF_FFFF_FFFF (−1).
- Divide by zero, X=5, Y=0: div → 0xFFFF_FFFF_FFFF_FFFF, rem → 5, both with DONE at edge 1. Overflow, X=0x8000_0000_0000_0000, Y=all ones: div → 0x8000_0000_0000_0000, rem → 0.
- Word mode, Is32Bit=1, X=0x0000_0001_0000_0064, Y=0xFFFF_FFFF_FFFF_FFF9: div → 0xFFFF_FFFF_FFFF_FFF2 (−14), DONE at edge 34. Word overflow, X low word=0x8000_0000, Y low word=0xFFFF_FFFF: div → 0xFFFF_FFFF_8000_0000.
- Abort and reset: start X=100, Y=7; assert KILL at edge 10 → IDLE at edge 11, no DONE, OUTPUT unchanged. Repeat with RST at edge 10 → OUTPUT=0, BUSY=0. Check that START with ALUOp=15'h0001 is ignored and that START while BUSY is ignored.
- With DIV_FASTZERO_EN: X=3, Y=10, div → 0 and rem → 3, both with DONE at edge 1. Without the macro, the same operations give DONE at edge 66.
